// File: rtl/z3_master_cycle_ctrl_if.sv
// Zorro III bus-master cycle interface.
// Groups the NCR-side request, the arbiter grant, the asynchronous Zorro
// termination inputs and the registered bus-control outputs.
//   master : the cycle controller (drives strobes, enables, terminations)
//   slave  : the surrounding logic (arbiter, NCR interface, Zorro bus)
interface z3_master_cycle_ctrl_if;
  logic       bus_granted;
  logic       ncr_req;
  logic       ncr_read;
  logic [1:0] ncr_siz;
  logic [1:0] ncr_a;
  logic       dtack_n_in;
  logic       berr_n_in;
  logic       ADDR_OE;
  logic       FCS_n;
  logic [3:0] DS_n;
  logic       DOE;
  logic       master_read;
  logic       ncr_ack;
  logic       ncr_berr;
  logic       busy;
  logic       timeout_flag;

  modport master (
    input  bus_granted, ncr_req, ncr_read, ncr_siz, ncr_a, dtack_n_in, berr_n_in,
    output ADDR_OE, FCS_n, DS_n, DOE, master_read, ncr_ack, ncr_berr, busy,
           timeout_flag
  );

  modport slave (
    output bus_granted, ncr_req, ncr_read, ncr_siz, ncr_a, dtack_n_in, berr_n_in,
    input  ADDR_OE, FCS_n, DS_n, DOE, master_read, ncr_ack, ncr_berr, busy,
           timeout_flag
  );
endinterface

// File: rtl/z3_master_cycle_ctrl.sv
// Zorro III bus-master data-cycle sequencer for the NCR 53C710.
// Once the bus is granted, runs one cycle: address enable, FCS_n, data
// strobes + DOE, wait for synchronised DTACK/BERR or timeout, then a
// one-cycle ncr_ack / ncr_berr and a recovery phase.
// Ports:
//   CLK  : 25 MHz system clock, rising edge
//   RST  : synchronous active-high reset
//   bus  : z3_master_cycle_ctrl_if.master (request, grant, DTACK_n/BERR_n in;
//          ADDR_OE, FCS_n, DS_n, DOE, master_read, ncr_ack, ncr_berr, busy,
//          timeout_flag out; all outputs registered)
module z3_master_cycle_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned ADDR_SETUP     = 1
) (
  input  logic                          CLK,
  input  logic                          RST,
  z3_master_cycle_ctrl_if.master        bus
);

  typedef enum logic [2:0] {
    IDLE, ADDR, STROBE, DATA, WAIT, TERM_OK, TERM_ERR, RECOVER
  } state_t;

  state_t     state;
  logic       dtk_meta_n, dtk_sync_n;
  logic       berr_meta_n, berr_sync_n;
  logic [1:0] setup_cnt;
  logic [7:0] tmo_cnt;
  logic [7:0] tmo_next;
  logic [3:0] lanes_q;
  logic       dtk, berr;

  // Active-low data strobes for the byte offsets A .. min(3, A+bytes-1);
  // DS_n[3] carries offset 0.
  function automatic logic [3:0] lane_decode(input logic [1:0] siz,
                                             input logic [1:0] a);
    logic [3:0] ds;
    logic [2:0] last;
    ds   = '1;
    last = {1'b0, a} + ((siz == 2'b00) ? 3'd3 : ({1'b0, siz} - 3'd1));
    for (int unsigned l = 0; l < 4; l++) begin
      if (l >= 32'(a) && l <= 32'(last)) ds[2'(3 - l)] = 1'b0;
    end
    return ds;
  endfunction

  always_comb begin
    dtk      = ~dtk_sync_n;
    berr     = ~berr_sync_n;
    tmo_next = tmo_cnt + 8'd1;
  end

  // Outputs are assigned together with the state they belong to, so each
  // output changes on the same edge the FSM enters the corresponding state.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state            <= IDLE;
      dtk_meta_n       <= 1'b1;
      dtk_sync_n       <= 1'b1;
      berr_meta_n      <= 1'b1;
      berr_sync_n      <= 1'b1;
      setup_cnt        <= '0;
      tmo_cnt          <= '0;
      lanes_q          <= '1;
      bus.ADDR_OE      <= 1'b0;
      bus.FCS_n        <= 1'b1;
      bus.DS_n         <= '1;
      bus.DOE          <= 1'b0;
      bus.master_read  <= 1'b0;
      bus.ncr_ack      <= 1'b0;
      bus.ncr_berr     <= 1'b0;
      bus.busy         <= 1'b0;
      bus.timeout_flag <= 1'b0;
    end else begin
      dtk_meta_n   <= bus.dtack_n_in;
      dtk_sync_n   <= dtk_meta_n;
      berr_meta_n  <= bus.berr_n_in;
      berr_sync_n  <= berr_meta_n;
      bus.ncr_ack  <= 1'b0;
      bus.ncr_berr <= 1'b0;

      case (state)
        IDLE: begin
          if (bus.ncr_req && bus.bus_granted) begin
            bus.master_read  <= bus.ncr_read;
            lanes_q          <= lane_decode(bus.ncr_siz, bus.ncr_a);
            bus.timeout_flag <= 1'b0;
            setup_cnt        <= 2'(ADDR_SETUP);
            bus.ADDR_OE      <= 1'b1;
            bus.busy         <= 1'b1;
            state            <= ADDR;
          end
        end
        ADDR: begin
          if (!bus.bus_granted) begin
            bus.ADDR_OE <= 1'b0;
            bus.busy    <= 1'b0;
            state       <= IDLE;
          end else begin
            setup_cnt <= setup_cnt - 2'd1;
            if (setup_cnt <= 2'd1) begin
              bus.FCS_n <= 1'b0;
              state     <= STROBE;
            end
          end
        end
        STROBE: begin
          bus.DOE  <= 1'b1;
          bus.DS_n <= lanes_q;
          state    <= DATA;
        end
        DATA: begin
          tmo_cnt <= '0;
          state   <= WAIT;
        end
        WAIT: begin
          tmo_cnt <= tmo_next;
          if (berr) begin
            bus.ncr_berr <= 1'b1;
            bus.DS_n     <= '1;
            bus.DOE      <= 1'b0;
            state        <= TERM_ERR;
          end else if (dtk) begin
            bus.ncr_ack <= 1'b1;
            bus.DS_n    <= '1;
            bus.DOE     <= 1'b0;
            state       <= TERM_OK;
          end else if (tmo_next == 8'(TIMEOUT_CYCLES)) begin
            bus.ncr_berr     <= 1'b1;
            bus.timeout_flag <= 1'b1;
            bus.DS_n         <= '1;
            bus.DOE          <= 1'b0;
            state            <= TERM_ERR;
          end
        end
        TERM_OK, TERM_ERR: begin
          bus.FCS_n <= 1'b1;
          state     <= RECOVER;
        end
        RECOVER: begin
          if (!dtk && !berr) begin
            bus.ADDR_OE <= 1'b0;
            bus.busy    <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/z3_master_cycle_ctrl.md
Name: z3_master_cycle_ctrl

Overview:
Sequences one Zorro III bus-master data cycle on behalf of the NCR 53C710 once the arbiter has granted the bus (BMASTER high). It drives address-buffer enable, FCS_n, DS_n and DOE in Zorro III order, and waits for a synchronised DTACK or BERR, or for a timeout. It then returns a one-cycle termination (ack or bus error) to the NCR-side logic. It sits between the zorro master arbiter, the buffer control block and the NCR master interface.

Parameters:
TIMEOUT_CYCLES, 255, CLK cycles spent in WAIT before the cycle is forced to a bus error (8-bit counter, 1..255).
ADDR_SETUP, 1, CLK cycles the address is held on the bus before FCS_n asserts (1..3).

Ports:
CLK  input  1  25 MHz system clock; all logic on its rising edge.
RST  input  1  synchronous, active-high reset.
bus_granted  input  1  bus mastership granted (BMASTER).
ncr_req  input  1  level; NCR requests a cycle; sampled only in IDLE.
ncr_read  input  1  1 = read, 0 = write; latched at request.
ncr_siz  input  2  68030-style transfer size (01 = 1 byte, 10 = 2, 11 = 3, 00 = 4); latched.
ncr_a  input  2  A[1:0] byte offset; latched.
dtack_n_in  input  1  Zorro DTACK_n, asynchronous.
berr_n_in  input  1  Zorro BERR_n, asynchronous.
ADDR_OE  output  1  enable the master address drivers onto the Zorro bus.
FCS_n  output  1  Zorro full cycle strobe.
DS_n  output  4  Zorro data strobes; DS_n[3] = D31:24 = byte offset 0.
DOE  output  1  data output enable.
master_read  output  1  latched ncr_read; direction for buffer control.
ncr_ack  output  1  one-cycle pulse: cycle completed normally.
ncr_berr  output  1  one-cycle pulse: cycle terminated by BERR or timeout.
busy  output  1  high in every state except IDLE.
timeout_flag  output  1  sticky; set on timeout, cleared on RST or on acceptance of the next ncr_req.

Behaviour:
- Reset (RST high at a rising edge) forces:
  - state IDLE;
  - FCS_n = 1, DS_n = 4'hF;
  - ADDR_OE, DOE, ncr_ack, ncr_berr, busy, timeout_flag, master_read = 0;
  - synchronisers = 1 (deasserted), counters = 0.
- RST overrides any state, including mid-cycle; no termination pulse is issued.
- dtack_n_in and berr_n_in pass through 2-flop synchronisers. Only the synchronised values (dtk, berr) are used.
- Byte-lane decode, fixed at latch time:
  - Active offsets run from A up to min(3, A + bytes − 1).
  - For each active offset L, DS_n[3−L] = 0.
  - Examples: siz = 00, A = 0 → 4'h0; siz = 10, A = 2 → 4'hC; siz = 01, A = 3 → 4'hE; siz = 00, A = 1 → 4'h8.
- State machine:
  - IDLE: wait for ncr_req && bus_granted. On that edge, latch read/siz/a, clear timeout_flag, load the setup counter with ADDR_SETUP, go to ADDR.
  - ADDR: ADDR_OE = 1, decrement the setup counter.
    - If bus_granted falls here, go to IDLE: no strobes, no pulse.
    - When the counter reaches 0, go to STROBE.
  - STROBE: FCS_n = 0. Next cycle go to DATA. Loss of grant is ignored from this state on; the cycle completes.
  - DATA: DOE = 1. DS_n = decoded lanes (writes: asserted the same cycle as DOE). Clear the timeout counter, go to WAIT.
  - WAIT: hold all strobes. Increment the timeout counter. Exits, in priority order:
    1. berr → TERM_ERR.
    2. dtk → TERM_OK.
    3. counter == TIMEOUT_CYCLES → TERM_ERR and set timeout_flag.
    - BERR wins over a simultaneous DTACK.
  - TERM_OK / TERM_ERR: raise ncr_ack / ncr_berr for exactly this cycle. DS_n = 4'hF, DOE = 0, FCS_n stays 0. Next state RECOVER.
  - RECOVER: FCS_n = 1, ADDR_OE = 1. Leave when dtk and berr are both deasserted; go to IDLE with ADDR_OE = 0.
- Minimum cycle (ADDR_SETUP = 1, DTACK already synchronised):
  - ncr_req to FCS_n low = 2 CLK;
  - FCS_n low to DS_n low = 1 CLK;
  - dtack_n_in low to ncr_ack = 3 CLK.
- Back-to-back: a new ncr_req is accepted no earlier than the cycle after RECOVER exits. ncr_req held high during a cycle does not start a second cycle early.
- All outputs are registered; no combinational path from any input to any output.

Test Plan:
- Long write: siz = 00, A = 0, read = 0, DTACK_n low 4 CLK after FCS_n → FCS_n low at +2, DS_n = 4'h0 with DOE = 1 at +3, ncr_ack single pulse 3 CLK after DTACK_n low, FCS_n high the next CLK, busy low after DTACK_n rises.
- Lane decode sweep: all 16 siz/A combinations → DS_n matches the decode rule (e.g. 10/2 → 4'hC, 01/3 → 4'hE, 00/1 → 4'h8, 11/0 → 4'h1).
- BERR and DTACK asserted on the same CLK during WAIT → ncr_berr pulses once, ncr_ack stays 0, timeout_flag stays 0.
- No response, TIMEOUT_CYCLES = 8 → ncr_berr pulse after 8 WAIT cycles, timeout_flag = 1; it clears on the next accepted ncr_req.
- bus_granted dropped during ADDR with ADDR_SETUP = 3 → FCS_n never asserts, no pulse, returns to IDLE. Grant dropped during WAIT → cycle completes with ncr_ack.
- RST asserted for one CLK during WAIT → next edge shows FCS_n = 1, DS_n = 4'hF, DOE = 0, busy = 0, no ack/berr pulse.
